// File: rtl/pipeline_sequencer.sv
// Stall/flush scheduler for the 5-stage pipeline: merges load-use, taken-branch and
// data-memory handshake into per-stage enables, counts events, halts on memory timeout.
module pipeline_sequencer #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             loaduse_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_we_o,
    output logic             memwb_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o,
    output logic [1:0]       state_o,
    output logic             err_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StRun     = 2'b01,
        StMemWait = 2'b10,
        StHalt    = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;
    logic [CNT_W-1:0]   memwait_q, memwait_d;
    logic               stall_inc, flush_inc, memwait_inc;

    // Next state, Mealy controls and counter increment requests.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        err_d          = err_q;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        memwait_inc    = 1'b0;
        // Idle/halt outputs: nothing advances, bubbles drain the back end.
        pc_we_o        = 1'b0;
        ifid_we_o      = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b1;
        exmem_we_o     = 1'b0;
        memwb_bubble_o = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (start_i) state_d = StRun;
            end
            StRun, StMemWait: begin
                if (!dmem_ready_i && (state_q == StMemWait || dmem_req_i)) begin
                    // Freeze: IDEX holds its contents, only MEMWB gets a bubble.
                    idex_bubble_o = 1'b0;
                    memwait_inc   = 1'b1;
                    if (state_q == StRun) begin
                        state_d = StMemWait;
                        wait_d  = WAIT_W'(1);
                    end else if (wait_q == WAIT_W'(MEM_TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end else begin
                    pc_we_o        = 1'b1;
                    ifid_we_o      = 1'b1;
                    idex_bubble_o  = 1'b0;
                    exmem_we_o     = 1'b1;
                    memwb_bubble_o = 1'b0;
                    // Load-use wins over branch: the held ID instruction re-resolves next cycle.
                    if (loaduse_i) begin
                        pc_we_o       = 1'b0;
                        ifid_we_o     = 1'b0;
                        idex_bubble_o = 1'b1;
                        stall_inc     = (state_q == StRun);
                    end else if (branch_taken_i) begin
                        ifid_flush_o = 1'b1;
                        flush_inc    = (state_q == StRun);
                    end
                    state_d = start_i ? StRun : StIdle;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating event counters.
    always_comb begin
        stall_d   = (stall_inc && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
        flush_d   = (flush_inc && flush_q != '1) ? flush_q + CNT_W'(1) : flush_q;
        memwait_d = (memwait_inc && memwait_q != '1) ? memwait_q + CNT_W'(1) : memwait_q;
    end

    // State, wait counter, error flag and counters.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= StIdle;
            wait_q    <= '0;
            err_q     <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            memwait_q <= memwait_d;
        end
    end

    assign stall_cnt_o   = stall_q;
    assign flush_cnt_o   = flush_q;
    assign memwait_cnt_o = memwait_q;
    assign state_o       = state_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a driver feeds directed and random inputs and
// pushes expected outputs from a reference model; a monitor pops and compares each cycle.
module tb_pipeline_sequencer;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 4;
    localparam int          SAT     = (1 << CNT_W) - 1;

    // Mode numbers follow the state_o encoding.
    localparam int MIdle = 0, MRun = 1, MWait = 2, MHalt = 3;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0, loaduse_i = 1'b0, branch_taken_i = 1'b0;
    logic             dmem_req_i = 1'b0, dmem_ready_i = 1'b0;
    logic             pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, exmem_we_o;
    logic             memwb_bubble_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o, memwait_cnt_o;
    logic [1:0]       state_o;

    pipeline_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .loaduse_i(loaduse_i),
        .branch_taken_i(branch_taken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .pc_we_o(pc_we_o), .ifid_we_o(ifid_we_o), .ifid_flush_o(ifid_flush_o),
        .idex_bubble_o(idex_bubble_o), .exmem_we_o(exmem_we_o),
        .memwb_bubble_o(memwb_bubble_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o),
        .memwait_cnt_o(memwait_cnt_o), .state_o(state_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble}
    localparam logic [5:0] CtlIdle   = 6'b000101;
    localparam logic [5:0] CtlFreeze = 6'b000001;
    localparam logic [5:0] CtlRun    = 6'b110010;
    localparam logic [5:0] CtlStall  = 6'b000110;
    localparam logic [5:0] CtlFlush  = 6'b111010;

    typedef struct {
        logic [5:0] ctl;
        int         st;
        logic       err;
        int         stall;
        int         flush;
        int         mw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state.
    int m_mode = MIdle, m_wait = 0, m_stall = 0, m_flush = 0, m_mw = 0;
    bit m_err = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    function automatic logic [5:0] ctl_now();
        return {pc_we_o, ifid_we_o, ifid_flush_o, idex_bubble_o, exmem_we_o, memwb_bubble_o};
    endfunction

    // Expected response for this cycle's inputs, then advance the model across the edge.
    task automatic model_step(input bit s, input bit lu, input bit br, input bit rq,
                              input bit rd);
        exp_t e;
        bit   waiting;
        e.ctl = CtlIdle; e.st = m_mode; e.err = m_err;
        e.stall = m_stall; e.flush = m_flush; e.mw = m_mw;
        sb.push_back(e);
        if (m_mode == MIdle) begin
            if (s) m_mode = MRun;
        end else if (m_mode == MRun || m_mode == MWait) begin
            waiting = !rd && (m_mode == MWait || rq);
            if (waiting) begin
                m_mw = sat_inc(m_mw);
                if (m_mode == MRun) begin
                    m_mode = MWait; m_wait = 1;
                end else if (m_wait == TIMEOUT) begin
                    m_err = 1'b1; m_mode = MHalt;
                end else begin
                    m_wait++;
                end
            end else begin
                if (m_mode == MRun && lu) m_stall = sat_inc(m_stall);
                else if (m_mode == MRun && br) m_flush = sat_inc(m_flush);
                m_mode = s ? MRun : MIdle;
            end
        end
        // Controls are the same function of pre-edge mode and inputs; recompute here.
        if (e.st == MRun || e.st == MWait) begin
            if (!rd && (e.st == MWait || rq)) sb[$].ctl = CtlFreeze;
            else if (lu) sb[$].ctl = CtlStall;
            else if (br) sb[$].ctl = CtlFlush;
            else sb[$].ctl = CtlRun;
        end
    endtask

    task automatic step(input bit s, input bit lu, input bit br, input bit rq, input bit rd);
        @(posedge clk_i);
        #1;
        start_i = s; loaduse_i = lu; branch_taken_i = br; dmem_req_i = rq; dmem_ready_i = rd;
        model_step(s, lu, br, rq, rd);
    endtask

    // Reset asserted between edges; outputs must be at reset values before the next edge.
    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        chk("rst_state", int'(state_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_stall", int'(stall_cnt_o), 0);
        chk("rst_flush", int'(flush_cnt_o), 0);
        chk("rst_memwait", int'(memwait_cnt_o), 0);
        chk("rst_ctl", int'(ctl_now()), int'(CtlIdle));
        @(posedge clk_i);
        #1;
        start_i = 0; loaduse_i = 0; branch_taken_i = 0; dmem_req_i = 0; dmem_ready_i = 0;
        rst_i = 1'b1;
        m_mode = MIdle; m_wait = 0; m_stall = 0; m_flush = 0; m_mw = 0; m_err = 1'b0;
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_i && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctl", int'(ctl_now()), int'(e.ctl));
            chk("state", int'(state_o), e.st);
            chk("err", int'(err_o), int'(e.err));
            chk("stall_cnt", int'(stall_cnt_o), e.stall);
            chk("flush_cnt", int'(flush_cnt_o), e.flush);
            chk("memwait_cnt", int'(memwait_cnt_o), e.mw);
        end
    end

    initial begin
        int rdy_pct;
        int halt_cycles;
        #12 rst_i = 1'b1;

        // Start-up: one idle cycle, then run.
        repeat (3) step(1, 0, 0, 0, 0);
        // Load-use masks the simultaneous branch; branch next cycle flushes.
        step(1, 1, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        // Three cycles waiting on memory, then completion.
        repeat (3) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        // Stall counter saturates.
        repeat (10) step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        do_reset();

        // Timeout into HALT; start toggling is ignored.
        step(1, 0, 0, 0, 0);
        repeat (6) step(1, 0, 0, 1, 0);
        repeat (4) step(1'($urandom_range(0, 1)), 1, 1, 1, 1);
        do_reset();

        // Reset mid memory wait.
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        repeat (2) step(1, 0, 0, 1, 0);
        do_reset();

        // Random traffic.
        rdy_pct = 70;
        halt_cycles = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) rdy_pct = ($urandom_range(0, 3) == 0) ? 30 : 75;
            if (m_mode == MHalt) halt_cycles++;
            if (halt_cycles >= 4 || (m_mode == MWait && $urandom_range(0, 19) == 0)) begin
                halt_cycles = 0;
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 95, $urandom_range(0, 99) < 20,
                     $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 40,
                     $urandom_range(0, 99) < rdy_pct);
            end
        end

        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
